// File: rtl/lsu_axi_param_if.sv
// AXI-Lite data-port bundle between the load/store unit (master) and the interconnect (slave).
// Widths follow the XLEN/ADDR_W of the LSU that drives it.
interface lsu_axi_param_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   localparam int NB = XLEN / 8;

   logic              ar_valid;
   logic              ar_ready;
   logic [ADDR_W-1:0] ar_addr;

   logic              r_valid;
   logic              r_ready;
   logic [XLEN-1:0]   r_data;
   logic [1:0]        r_resp;

   logic              aw_valid;
   logic              aw_ready;
   logic [ADDR_W-1:0] aw_addr;

   logic              w_valid;
   logic              w_ready;
   logic [XLEN-1:0]   w_data;
   logic [NB-1:0]     w_strb;

   logic              b_valid;
   logic              b_ready;
   logic [1:0]        b_resp;

   modport master (
      output ar_valid, ar_addr, input ar_ready,
      input  r_valid, r_data, r_resp, output r_ready,
      output aw_valid, aw_addr, input aw_ready,
      output w_valid, w_data, w_strb, input w_ready,
      input  b_valid, b_resp, output b_ready
   );

   modport slave (
      input  ar_valid, ar_addr, output ar_ready,
      output r_valid, r_data, r_resp, input r_ready,
      input  aw_valid, aw_addr, output aw_ready,
      input  w_valid, w_data, w_strb, output w_ready,
      output b_valid, b_resp, input b_ready
   );
endinterface

// File: rtl/lsu_axi_param.sv
// Load/store unit: latches one EXU op, runs it over AXI-Lite with lane steering and
// strobes, extends load data and returns a single writeback pulse with an error code.
module lsu_axi_param #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m_valid_i,
   output logic              m_ready_o,
   input  logic              ren_i,
   input  logic              wen_i,
   input  logic              signed_i,
   input  logic [1:0]        size_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [XLEN-1:0]   wdata_i,
   output logic              wb_valid_o,
   output logic [XLEN-1:0]   rdata_o,
   output logic [1:0]        err_o,
   lsu_axi_param_if.master   mst
);
   localparam int NB = XLEN / 8;
   localparam int LW = $clog2(NB);

   typedef enum logic [5:0] {
      S_IDLE  = 6'b000001,
      S_RD_A  = 6'b000010,
      S_RD_D  = 6'b000100,
      S_WR_AW = 6'b001000,
      S_WR_B  = 6'b010000,
      S_WB    = 6'b100000
   } state_e;

   state_e            state_q, state_d;
   logic              signed_q, signed_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic [1:0]        err_q, err_d;

   logic              accept;
   logic              misaligned;
   logic [1:0]        acc_err;
   logic [LW-1:0]     lane;
   logic [XLEN-1:0]   sh;
   logic [XLEN-1:0]   ext;
   logic [7:0]        size_mask;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         signed_q  <= 1'b0;
         size_q    <= 2'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 2'd0;
      end else begin
         state_q   <= state_d;
         signed_q  <= signed_d;
         size_q    <= size_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   // Accept-time checks; an illegal size outranks misalignment.
   always_comb begin
      accept = m_valid_i && (state_q == S_IDLE);
      case (size_i)
         2'd1:    misaligned = addr_i[0];
         2'd2:    misaligned = |addr_i[1:0];
         2'd3:    misaligned = |addr_i[2:0];
         default: misaligned = 1'b0;
      endcase
      if (size_i == 2'd3 && XLEN == 32) acc_err = 2'd3;
      else if (misaligned)              acc_err = 2'd1;
      else                              acc_err = 2'd0;
   end

   always_comb begin
      lane = addr_q[LW-1:0];
      sh   = mst.r_data >> {lane, 3'b000};
      case (size_q)
         2'd0:    ext = signed_q ? XLEN'($signed(sh[7:0]))  : XLEN'(sh[7:0]);
         2'd1:    ext = signed_q ? XLEN'($signed(sh[15:0])) : XLEN'(sh[15:0]);
         2'd2:    ext = signed_q ? XLEN'($signed(sh[31:0])) : XLEN'(sh[31:0]);
         default: ext = sh;
      endcase
      case (size_q)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (acc_err != 2'd0) state_d = S_WB;
               else if (ren_i)      state_d = S_RD_A;
               else if (wen_i)      state_d = S_WR_AW;
               else                 state_d = S_WB;
            end
         end
         S_RD_A:  if (mst.ar_ready) state_d = S_RD_D;
         S_RD_D:  if (mst.r_valid)  state_d = S_WB;
         S_WR_AW: if ((aw_done_q || mst.aw_ready) && (w_done_q || mst.w_ready)) state_d = S_WR_B;
         S_WR_B:  if (mst.b_valid)  state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Result registers only change on the edge that enters WB, so they hold between pulses.
   always_comb begin
      signed_d  = signed_q;
      size_d    = size_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      rdata_d   = rdata_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               signed_d = signed_i;
               size_d   = size_i;
               addr_d   = addr_i;
               wdata_d  = wdata_i;
               if (acc_err != 2'd0 || (!ren_i && !wen_i)) begin
                  err_d   = acc_err;
                  rdata_d = '0;
               end
            end
         end
         S_RD_D: begin
            if (mst.r_valid) begin
               err_d   = (mst.r_resp != 2'd0) ? 2'd2 : 2'd0;
               rdata_d = (mst.r_resp != 2'd0) ? '0 : ext;
            end
         end
         S_WR_AW: begin
            aw_done_d = aw_done_q || mst.aw_ready;
            w_done_d  = w_done_q || mst.w_ready;
         end
         S_WR_B: begin
            if (mst.b_valid) begin
               err_d   = (mst.b_resp != 2'd0) ? 2'd2 : 2'd0;
               rdata_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      m_ready_o    = (state_q == S_IDLE);
      wb_valid_o   = (state_q == S_WB);
      mst.ar_valid = (state_q == S_RD_A);
      mst.r_ready  = (state_q == S_RD_D);
      mst.aw_valid = (state_q == S_WR_AW) && !aw_done_q;
      mst.w_valid  = (state_q == S_WR_AW) && !w_done_q;
      mst.b_ready  = (state_q == S_WR_B);
      mst.ar_addr  = {addr_q[ADDR_W-1:LW], {LW{1'b0}}};
      mst.aw_addr  = {addr_q[ADDR_W-1:LW], {LW{1'b0}}};
      mst.w_data   = wdata_q << {lane, 3'b000};
      mst.w_strb   = size_mask[NB-1:0] << lane;
   end

   assign rdata_o = rdata_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_lsu_axi_param.sv
// Bench for lsu_axi_param: a 32-bit and a 64-bit instance share one stimulus/slave model;
// an arithmetic reference predicts every op and a per-cycle monitor checks the bus and results.
module tb_lsu_axi_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        m_valid;
   logic        ren, wen, sgn;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [63:0] wdata;
   logic        sel64;

   logic        s_ar_ready, s_r_valid, s_aw_ready, s_w_ready, s_b_valid;
   logic [63:0] s_r_data;
   logic [1:0]  s_r_resp, s_b_resp;

   logic        m_ready32, wb32, m_ready64, wb64;
   logic [31:0] rdata32;
   logic [63:0] rdata64;
   logic [1:0]  err32, err64;

   lsu_axi_param_if #(.XLEN(32), .ADDR_W(32)) bus32 ();
   lsu_axi_param_if #(.XLEN(64), .ADDR_W(32)) bus64 ();

   lsu_axi_param #(.XLEN(32), .ADDR_W(32)) dut32 (
      .clk_i(clk), .rst_i(rst), .m_valid_i(m_valid && !sel64), .m_ready_o(m_ready32),
      .ren_i(ren), .wen_i(wen), .signed_i(sgn), .size_i(size), .addr_i(addr),
      .wdata_i(wdata[31:0]), .wb_valid_o(wb32), .rdata_o(rdata32), .err_o(err32),
      .mst(bus32)
   );

   lsu_axi_param #(.XLEN(64), .ADDR_W(32)) dut64 (
      .clk_i(clk), .rst_i(rst), .m_valid_i(m_valid && sel64), .m_ready_o(m_ready64),
      .ren_i(ren), .wen_i(wen), .signed_i(sgn), .size_i(size), .addr_i(addr),
      .wdata_i(wdata), .wb_valid_o(wb64), .rdata_o(rdata64), .err_o(err64),
      .mst(bus64)
   );

   // Slave-side inputs are shared by both instances; only the selected one is ever busy.
   assign bus32.ar_ready = s_ar_ready;
   assign bus32.r_valid  = s_r_valid;
   assign bus32.r_data   = s_r_data[31:0];
   assign bus32.r_resp   = s_r_resp;
   assign bus32.aw_ready = s_aw_ready;
   assign bus32.w_ready  = s_w_ready;
   assign bus32.b_valid  = s_b_valid;
   assign bus32.b_resp   = s_b_resp;
   assign bus64.ar_ready = s_ar_ready;
   assign bus64.r_valid  = s_r_valid;
   assign bus64.r_data   = s_r_data;
   assign bus64.r_resp   = s_r_resp;
   assign bus64.aw_ready = s_aw_ready;
   assign bus64.w_ready  = s_w_ready;
   assign bus64.b_valid  = s_b_valid;
   assign bus64.b_resp   = s_b_resp;

   // Observed outputs of whichever instance is under test.
   logic        o_m_ready, o_wb, o_ar_valid, o_r_ready, o_aw_valid, o_w_valid, o_b_ready;
   logic [63:0] o_rdata, o_w_data;
   logic [31:0] o_ar_addr, o_aw_addr;
   logic [7:0]  o_w_strb;
   logic [1:0]  o_err;
   assign o_m_ready  = sel64 ? m_ready64 : m_ready32;
   assign o_wb       = sel64 ? wb64 : wb32;
   assign o_rdata    = sel64 ? rdata64 : {32'b0, rdata32};
   assign o_err      = sel64 ? err64 : err32;
   assign o_ar_valid = sel64 ? bus64.ar_valid : bus32.ar_valid;
   assign o_ar_addr  = sel64 ? bus64.ar_addr : bus32.ar_addr;
   assign o_r_ready  = sel64 ? bus64.r_ready : bus32.r_ready;
   assign o_aw_valid = sel64 ? bus64.aw_valid : bus32.aw_valid;
   assign o_aw_addr  = sel64 ? bus64.aw_addr : bus32.aw_addr;
   assign o_w_valid  = sel64 ? bus64.w_valid : bus32.w_valid;
   assign o_w_data   = sel64 ? bus64.w_data : {32'b0, bus32.w_data};
   assign o_w_strb   = sel64 ? bus64.w_strb : {4'b0, bus32.w_strb};
   assign o_b_ready  = sel64 ? bus64.b_ready : bus32.b_ready;

   int errors = 0;
   int checks = 0;

   // Expected results of the op in flight, filled by model_op.
   logic [1:0]  exp_err;
   logic [63:0] exp_rdata, exp_wdata;
   logic [31:0] exp_addr;
   logic [7:0]  exp_strb;
   bit          exp_traffic, exp_load, exp_store;

   // Handshake history and captured results of the op in flight.
   bit          op_active = 0;
   bit          ar_seen, r_seen, aw_seen, w_seen, b_seen, wb_seen, resp_done;
   int          cyc, wb_cyc, wb_count, ar_cycles, aw_cycles, w_cycles;
   logic [63:0] got_rdata;
   logic [1:0]  got_err;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference behaviour from the arithmetic rules: byte lanes, strobes, extension, errors.
   function automatic void model_op(input int xlen, input bit r, input bit w, input bit s,
                                    input int sz, input longint unsigned a,
                                    input longint unsigned wd, input longint unsigned rbus,
                                    input int resp);
      int nb    = xlen / 8;
      int lane  = int'(a % longint'(nb));
      int bytes = 1 << sz;
      int bits  = 8 * bytes;
      longint unsigned xmask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
      longint unsigned val, fmask;
      exp_err = 2'd0;
      if (sz == 3 && xlen == 32)            exp_err = 2'd3;
      else if (a % longint'(bytes) != 0)    exp_err = 2'd1;
      exp_traffic = (exp_err == 2'd0) && (r || w);
      exp_load    = r;
      exp_store   = w;
      exp_addr    = 32'(a - longint'(lane));
      exp_wdata   = ((wd & xmask) << (8 * lane)) & xmask;
      exp_strb    = 8'((((1 << bytes) - 1) << lane) & ((1 << nb) - 1));
      exp_rdata   = 64'd0;
      if (exp_traffic && resp != 0) exp_err = 2'd2;
      if (exp_traffic && r && resp == 0) begin
         val   = (rbus & xmask) >> (8 * lane);
         fmask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 1);
         val   = val & fmask;
         if (s && bits < 64 && ((val >> (bits - 1)) & 1) == 1) val = val | ~fmask;
         exp_rdata = val & xmask;
      end
   endfunction

   // Per-cycle monitor: bus behaviour, wb pulse timing and results against the model,
   // then record which handshakes complete on the coming edge.
   always @(negedge clk) begin
      if (op_active) begin
         resp_done = exp_traffic ? (exp_load ? r_seen : b_seen) : 1'b1;
         checkOutput("m_ready busy", o_m_ready, 0);
         checkOutput("ar_valid", o_ar_valid, exp_traffic && exp_load && !ar_seen);
         checkOutput("r_ready", o_r_ready, ar_seen && !r_seen);
         checkOutput("aw_valid", o_aw_valid, exp_traffic && exp_store && !aw_seen);
         checkOutput("w_valid", o_w_valid, exp_traffic && exp_store && !w_seen);
         checkOutput("b_ready", o_b_ready, aw_seen && w_seen && !b_seen);
         checkOutput("wb_valid", o_wb, resp_done && !wb_seen);
         if (o_ar_valid) begin
            checkOutput("ar_addr", o_ar_addr, exp_addr);
            ar_cycles++;
         end
         if (o_aw_valid) begin
            checkOutput("aw_addr", o_aw_addr, exp_addr);
            aw_cycles++;
         end
         if (o_w_valid) begin
            checkOutput("w_data", o_w_data, exp_wdata);
            checkOutput("w_strb", o_w_strb, exp_strb);
            w_cycles++;
         end
         if (o_wb) begin
            checkOutput("rdata", o_rdata, exp_rdata);
            checkOutput("err", o_err, exp_err);
            got_rdata = o_rdata;
            got_err   = o_err;
            wb_seen   = 1;
            wb_cyc    = cyc;
            wb_count++;
         end
         if (o_ar_valid && s_ar_ready) ar_seen = 1;
         if (o_r_ready && s_r_valid)   r_seen  = 1;
         if (o_aw_valid && s_aw_ready) aw_seen = 1;
         if (o_w_valid && s_w_ready)   w_seen  = 1;
         if (o_b_ready && s_b_valid)   b_seen  = 1;
         cyc++;
      end
   end

   // Issue one op, then play the AXI slave with the given ready delays (cycles after accept).
   task automatic applyStimulus(input bit x64, input bit r, input bit w, input bit s,
                                input logic [1:0] sz, input logic [31:0] a,
                                input logic [63:0] wd, input logic [63:0] rbus,
                                input logic [1:0] resp, input int ar_dly,
                                input int aw_dly, input int w_dly);
      model_op(x64 ? 64 : 32, r, w, s, int'(sz), longint'(a), wd, rbus, int'(resp));
      @(posedge clk); #1;
      sel64 = x64; ren = r; wen = w; sgn = s; size = sz; addr = a; wdata = wd;
      m_valid = 1;
      ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0; wb_seen = 0;
      cyc = 0; wb_cyc = -1; wb_count = 0; ar_cycles = 0; aw_cycles = 0; w_cycles = 0;
      got_rdata = '0; got_err = '0;
      @(negedge clk);
      checkOutput("idle m_ready", o_m_ready, 1);
      @(posedge clk); #1;
      m_valid = 0;
      ren = ~r; wen = 0; sgn = ~s; size = ~sz; addr = ~a; wdata = ~wd;
      op_active = 1;
      for (int k = 0; k < 40 && !wb_seen; k++) begin
         s_ar_ready = (cyc >= ar_dly);
         s_r_valid  = ar_seen && !r_seen;
         s_r_data   = rbus;
         s_r_resp   = resp;
         s_aw_ready = (cyc >= aw_dly);
         s_w_ready  = (cyc >= w_dly);
         s_b_valid  = aw_seen && w_seen && !b_seen;
         s_b_resp   = resp;
         @(posedge clk); #1;
      end
      if (!wb_seen) checkOutput("wb timeout", 0, 1);
      op_active = 0;
      s_ar_ready = 0; s_r_valid = 0; s_aw_ready = 0; s_w_ready = 0; s_b_valid = 0;
      @(negedge clk);
      checkOutput("back to idle", o_m_ready, 1);
      checkOutput("single wb pulse", o_wb, 0);
      checkOutput("wb count", wb_count, 1);
      checkOutput("rdata hold", o_rdata, got_rdata);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1; m_valid = 0; ren = 0; wen = 0; sgn = 0; size = 0; addr = 0; wdata = 0;
      sel64 = 0;
      s_ar_ready = 0; s_r_valid = 0; s_aw_ready = 0; s_w_ready = 0; s_b_valid = 0;
      s_r_data = 0; s_r_resp = 0; s_b_resp = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      @(negedge clk);
      checkOutput("reset m_ready32", m_ready32, 1);
      checkOutput("reset m_ready64", m_ready64, 1);
      checkOutput("reset wb", {wb32, wb64}, 0);
      checkOutput("reset rdata", rdata64 | {32'b0, rdata32}, 0);
      checkOutput("reset err", {err32, err64}, 0);
      checkOutput("reset valids32", {bus32.ar_valid, bus32.aw_valid, bus32.w_valid,
                                     bus32.r_ready, bus32.b_ready}, 0);
      checkOutput("reset valids64", {bus64.ar_valid, bus64.aw_valid, bus64.w_valid,
                                     bus64.r_ready, bus64.b_ready}, 0);

      // Signed byte load from lane 3 with a slow address channel.
      applyStimulus(0, 1, 0, 1, 2'd0, 32'h8000_0003, 64'd0, 64'h80FF_FF12, 2'd0, 3, 0, 0);
      checkOutput("lb rdata", got_rdata, 64'hFFFF_FF80);
      checkOutput("lb err", got_err, 0);
      checkOutput("lb ar cycles", ar_cycles, 4);
      checkOutput("lb wb cycle", wb_cyc, 5);

      // Half store on lane 2; write address lands before write data.
      applyStimulus(0, 0, 1, 0, 2'd1, 32'h8000_0002, 64'h0000_BEEF, 64'd0, 2'd0, 0, 1, 3);
      checkOutput("sh aw cycles", aw_cycles, 2);
      checkOutput("sh w cycles", w_cycles, 4);
      checkOutput("sh wb cycle", wb_cyc, 5);
      checkOutput("sh err", got_err, 0);

      // Misaligned word, and a dword on the 32-bit unit (size error outranks alignment).
      applyStimulus(0, 1, 0, 0, 2'd2, 32'h8000_0006, 64'd0, 64'd0, 2'd0, 0, 0, 0);
      checkOutput("lw misaligned err", got_err, 1);
      checkOutput("lw misaligned wb cycle", wb_cyc, 0);
      checkOutput("lw misaligned ar cycles", ar_cycles, 0);
      applyStimulus(0, 1, 0, 0, 2'd3, 32'h8000_0004, 64'd0, 64'd0, 2'd0, 0, 0, 0);
      checkOutput("ld on 32 err", got_err, 3);

      // Bus errors on both directions.
      applyStimulus(0, 0, 1, 0, 2'd2, 32'h8000_0010, 64'h1234_5678, 64'd0, 2'd2, 0, 0, 0);
      checkOutput("sw slverr err", got_err, 2);
      checkOutput("sw slverr wb cycle", wb_cyc, 2);
      applyStimulus(0, 1, 0, 0, 2'd1, 32'h8000_0012, 64'd0, 64'hFFFF_FFFF, 2'd3, 1, 0, 0);
      checkOutput("lh decerr err", got_err, 2);
      checkOutput("lh decerr rdata", got_rdata, 0);

      // Signed half with negative value, then a non-memory op must clear rdata.
      applyStimulus(0, 1, 0, 1, 2'd1, 32'h8000_0002, 64'd0, 64'h8001_7FFF, 2'd0, 0, 0, 0);
      checkOutput("lh signed rdata", got_rdata, 64'hFFFF_8001);
      applyStimulus(0, 0, 0, 0, 2'd2, 32'h0000_0000, 64'd0, 64'd0, 2'd0, 0, 0, 0);
      checkOutput("nop rdata", got_rdata, 0);
      checkOutput("nop wb cycle", wb_cyc, 0);

      // 64-bit instance: upper-word loads and a full-width store.
      applyStimulus(1, 1, 0, 0, 2'd2, 32'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 2'd0, 0, 0, 0);
      checkOutput("lwu64 rdata", got_rdata, 64'h0000_0000_8765_4321);
      applyStimulus(1, 1, 0, 1, 2'd2, 32'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 2'd0, 2, 0, 0);
      checkOutput("lw64 signed rdata", got_rdata, 64'hFFFF_FFFF_8765_4321);
      applyStimulus(1, 0, 1, 0, 2'd3, 32'h8000_0008, 64'h1122_3344_5566_7788, 64'd0, 2'd0, 0, 2, 0);
      checkOutput("sd64 err", got_err, 0);
      applyStimulus(1, 0, 1, 0, 2'd0, 32'h8000_0007, 64'h0000_00A5, 64'd0, 2'd0, 1, 0, 1);
      applyStimulus(1, 1, 0, 1, 2'd3, 32'h8000_0010, 64'd0, 64'hF000_0000_0000_0001, 2'd0, 0, 0, 0);
      checkOutput("ld64 rdata", got_rdata, 64'hF000_0000_0000_0001);

      // Reset while waiting for read data: the op is dropped without a wb pulse.
      @(posedge clk); #1;
      sel64 = 0; ren = 1; wen = 0; sgn = 0; size = 2'd2; addr = 32'h8000_0020;
      m_valid = 1; s_ar_ready = 1;
      @(posedge clk); #1;
      m_valid = 0;
      @(posedge clk); #1;
      s_ar_ready = 0;
      @(negedge clk);
      checkOutput("pre-reset r_ready", o_r_ready, 1);
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      s_r_valid = 1; s_r_data = 64'h1;
      @(negedge clk);
      checkOutput("post-reset r_ready", o_r_ready, 0);
      checkOutput("post-reset m_ready", o_m_ready, 1);
      checkOutput("post-reset ar_valid", o_ar_valid, 0);
      wb_count = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (o_wb) wb_count++;
      end
      checkOutput("no wb after reset", wb_count, 0);
      s_r_valid = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
